// File: rtl/psum_ctrl_pkg.sv
// Shared definitions for the psum GBF drain controllers.
//   drain_state_e     : drain sequencer states
//   DRAIN_FIFO_DEPTH  : entries in the read-data staging FIFO
//   DRAIN_FIFO_CNT_W  : width of that FIFO's occupancy count
package psum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CLEAR,
    ST_DONE
  } drain_state_e;

  localparam int unsigned DRAIN_FIFO_DEPTH = 2;
  localparam int unsigned DRAIN_FIFO_CNT_W = $clog2(DRAIN_FIFO_DEPTH + 1);

endpackage

// File: rtl/psum_gbf_drain_ctrl_if.sv
// Output SRAM write stream (valid/ready beats).
//   sram_valid : beat valid               (master -> slave)
//   sram_ready : slave accepts on valid&ready (slave -> master)
//   sram_data  : beat payload             (master -> slave)
//   sram_addr  : beat address             (master -> slave)
interface psum_gbf_drain_ctrl_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 16
);
  logic              sram_valid;
  logic              sram_ready;
  logic [DATA_W-1:0] sram_data;
  logic [ADDR_W-1:0] sram_addr;

  modport master (output sram_valid, output sram_data, output sram_addr, input sram_ready);
  modport slave  (input sram_valid, input sram_data, input sram_addr, output sram_ready);
endinterface

// File: rtl/drain_fifo2.sv
// Two-entry valid/ready staging FIFO with an occupancy count.
//   in_valid/in_data   : push side; the writer must keep count + outstanding < 2
//   out_valid/out_data : head entry, held stable until out_ready
//   count              : current occupancy (0..2)
// Reset is asynchronous, active-high.
module drain_fifo2
  import psum_ctrl_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [DRAIN_FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]            mem_q [DRAIN_FIFO_DEPTH];
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [DRAIN_FIFO_CNT_W-1:0] count_q, count_d;
  logic                        push, pop;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    push     = in_valid;
    pop      = out_valid & out_ready;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + DRAIN_FIFO_CNT_W'(push) - DRAIN_FIFO_CNT_W'(pop);
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides validity and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/psum_gbf_drain_ctrl.sv
// Drains the just-filled psum GBF bank to output SRAM, then zero-clears it.
//   psum_gbf_w_num / conv_finish : bank-swap and final-result indications from the adder
//   gbf_r_*                      : GBF read port (data returns one cycle after gbf_r_en)
//   gbf_clr_*                    : GBF zero-write port
//   sram                         : output SRAM beat stream (master side)
//   bank_free                    : one-cycle pulse when a bank finishes clearing
//   done / overrun_err           : sticky final-drain-complete and lost-swap flags
// Reset is asynchronous, active-high.
module psum_gbf_drain_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH  = 512,
  parameter int GBF_ADDR_BITWIDTH  = 5,
  parameter int DEPTH              = 32,
  parameter int SRAM_ADDR_BITWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         psum_gbf_w_num,
  input  logic                         conv_finish,
  output logic                         gbf_r_en,
  output logic                         gbf_r_bank,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_r_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0] gbf_r_data,
  output logic                         gbf_clr_en,
  output logic                         gbf_clr_bank,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_clr_addr,
  psum_gbf_drain_ctrl_if.master        sram,
  output logic                         bank_free,
  output logic                         done,
  output logic                         overrun_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = DRAIN_FIFO_CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] SLOTS_C = OCC_W'(DRAIN_FIFO_DEPTH);

  drain_state_e                  state_q, state_d;
  logic                          w_num_q, w_num_d;
  logic                          pend_q, pend_d, pend_bank_q, pend_bank_d;
  logic                          fin_q, fin_d, fin_bank_q, fin_bank_d;
  logic                          bank_q, bank_d, final_q, final_d;
  logic [CNT_W-1:0]              rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]              beat_q, beat_d;
  logic [CNT_W-1:0]              clr_cnt_q, clr_cnt_d;
  logic                          inflight_q, inflight_d;
  logic [SRAM_ADDR_BITWIDTH-1:0] base_q, base_d;
  logic                          overrun_q, overrun_d;

  logic [DRAIN_FIFO_CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]              occ;
  logic                          fire, rd_en, clr_en;

  drain_fifo2 #(.WIDTH(GBF_DATA_BITWIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (gbf_r_data),
    .out_valid (sram.sram_valid),
    .out_data  (sram.sram_data),
    .out_ready (sram.sram_ready),
    .count     (fifo_count)
  );

  assign fire = sram.sram_valid & sram.sram_ready;
  // Slots still claimed after this cycle's pop; counting the pop keeps 1 beat/cycle.
  assign occ  = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(fire);

  always_comb begin
    state_d     = state_q;
    w_num_d     = psum_gbf_w_num;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    fin_d       = fin_q;
    fin_bank_d  = fin_bank_q;
    bank_d      = bank_q;
    final_d     = final_q;
    rd_cnt_d    = rd_cnt_q;
    beat_d      = beat_q;
    clr_cnt_d   = clr_cnt_q;
    base_d      = base_q;
    overrun_d   = overrun_q;
    rd_en       = 1'b0;
    clr_en      = 1'b0;
    bank_free   = 1'b0;

    if (conv_finish && !fin_q) begin
      fin_d      = 1'b1;
      fin_bank_d = psum_gbf_w_num;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_READ;
          bank_d  = pend_bank_q;
          final_d = 1'b0;
          pend_d  = 1'b0;
        end else if (fin_q) begin
          state_d = ST_READ;
          bank_d  = fin_bank_q;
          final_d = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_cnt_q < DEPTH_C && occ < SLOTS_C) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (fire) begin
          if (beat_q == LAST_C) begin
            beat_d   = '0;
            rd_cnt_d = '0;
            state_d  = ST_CLEAR;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (clr_cnt_q == LAST_C) begin
          clr_cnt_d = '0;
          bank_free = 1'b1;
          base_d    = base_q + SRAM_ADDR_BITWIDTH'(DEPTH);
          state_d   = final_q ? ST_DONE : ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: ;  // ST_DONE is terminal until reset
    endcase

    // Evaluated after the IDLE dispatch so a pend consumed this cycle frees the slot.
    if (psum_gbf_w_num != w_num_q && state_q != ST_DONE) begin
      if (pend_d) begin
        overrun_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_bank_d = w_num_q;
      end
    end

    inflight_d = rd_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      w_num_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      fin_q       <= 1'b0;
      fin_bank_q  <= 1'b0;
      bank_q      <= 1'b0;
      final_q     <= 1'b0;
      rd_cnt_q    <= '0;
      beat_q      <= '0;
      clr_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      base_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_num_q     <= w_num_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      fin_q       <= fin_d;
      fin_bank_q  <= fin_bank_d;
      bank_q      <= bank_d;
      final_q     <= final_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_q      <= beat_d;
      clr_cnt_q   <= clr_cnt_d;
      inflight_q  <= inflight_d;
      base_q      <= base_d;
      overrun_q   <= overrun_d;
    end
  end

  assign gbf_r_en     = rd_en;
  assign gbf_r_bank   = rd_en & bank_q;
  assign gbf_r_addr   = rd_en ? GBF_ADDR_BITWIDTH'(rd_cnt_q) : '0;
  assign gbf_clr_en   = clr_en;
  assign gbf_clr_bank = clr_en & bank_q;
  assign gbf_clr_addr = clr_en ? GBF_ADDR_BITWIDTH'(clr_cnt_q) : '0;
  assign sram.sram_addr = base_q + SRAM_ADDR_BITWIDTH'(beat_q);
  assign done         = (state_q == ST_DONE);
  assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_psum_gbf_drain_ctrl.sv
// Scoreboard bench for psum_gbf_drain_ctrl: a GBF memory model answers reads and
// clears, expected beats/clears are queued when a drain is triggered and popped
// as the DUT produces them.
module tb_psum_gbf_drain_ctrl;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int SAW = 6;

  typedef struct {
    logic [DW-1:0]  data;
    logic [SAW-1:0] addr;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic psum_gbf_w_num = 1'b0;
  logic conv_finish = 1'b0;
  logic gbf_r_en, gbf_r_bank, gbf_clr_en, gbf_clr_bank;
  logic [AW-1:0] gbf_r_addr, gbf_clr_addr;
  logic [DW-1:0] gbf_r_data = '0;
  logic bank_free, done, overrun_err;

  psum_gbf_drain_ctrl_if #(.DATA_W(DW), .ADDR_W(SAW)) sram_if ();

  psum_gbf_drain_ctrl #(
    .GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW), .DEPTH(DEPTH), .SRAM_ADDR_BITWIDTH(SAW)
  ) dut (
    .clk(clk), .reset(reset), .psum_gbf_w_num(psum_gbf_w_num), .conv_finish(conv_finish),
    .gbf_r_en(gbf_r_en), .gbf_r_bank(gbf_r_bank), .gbf_r_addr(gbf_r_addr), .gbf_r_data(gbf_r_data),
    .gbf_clr_en(gbf_clr_en), .gbf_clr_bank(gbf_clr_bank), .gbf_clr_addr(gbf_clr_addr),
    .sram(sram_if.master),
    .bank_free(bank_free), .done(done), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int free_cnt = 0;
  int stall_cnt = 0;
  logic ready_mode = 1'b0;
  logic [SAW-1:0] exp_base = '0;

  logic [DW-1:0] gbf_mem [2][DEPTH];
  beat_t exp_q[$];
  logic [AW:0] clr_q[$];

  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [SAW-1:0] prev_addr;
  beat_t mon_b;
  logic [AW:0] mon_c;

  // GBF model: read data one cycle after the strobe, zero-write on clear.
  always @(posedge clk) begin
    if (gbf_r_en) gbf_r_data <= gbf_mem[gbf_r_bank][gbf_r_addr];
    if (gbf_clr_en) gbf_mem[gbf_clr_bank][gbf_clr_addr] = '0;
  end

  // SRAM ready: held high, or toggled every cycle when ready_mode is set.
  always @(posedge clk) begin
    #1;
    sram_if.sram_ready = ready_mode ? ~sram_if.sram_ready : 1'b1;
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      n_vec++;
      if (gbf_r_en && gbf_clr_en) begin
        n_err++;
        $display("FAIL rd_clr_overlap: got r_en=1 clr_en=1, required not both");
      end
      if (prev_stall) begin
        n_vec++;
        if (sram_if.sram_valid !== 1'b1 || sram_if.sram_data !== prev_data || sram_if.sram_addr !== prev_addr) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b addr=%0d, required valid=1 addr=%0d unchanged data",
                   sram_if.sram_valid, sram_if.sram_addr, prev_addr);
        end
      end
      prev_stall = sram_if.sram_valid && !sram_if.sram_ready;
      if (prev_stall) stall_cnt++;
      prev_data = sram_if.sram_data;
      prev_addr = sram_if.sram_addr;
      if (sram_if.sram_valid && sram_if.sram_ready) begin
        beat_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got beat at addr=%0d, required no beat", sram_if.sram_addr);
        end else begin
          mon_b = exp_q.pop_front();
          if (sram_if.sram_addr !== mon_b.addr || sram_if.sram_data !== mon_b.data) begin
            n_err++;
            $display("FAIL beat: got addr=%0d data=%h, required addr=%0d data=%h",
                     sram_if.sram_addr, sram_if.sram_data[63:0], mon_b.addr, mon_b.data[63:0]);
          end
        end
      end
      if (gbf_clr_en) begin
        n_vec++;
        if (clr_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_clear: got bank=%0d addr=%0d, required none", gbf_clr_bank, gbf_clr_addr);
        end else begin
          mon_c = clr_q.pop_front();
          if ({gbf_clr_bank, gbf_clr_addr} !== mon_c) begin
            n_err++;
            $display("FAIL clear: got bank/addr=%0h, required %0h", {gbf_clr_bank, gbf_clr_addr}, mon_c);
          end
        end
      end
      if (bank_free) free_cnt++;
    end
  end

  function automatic logic [535:0] all_outs();
    return {gbf_r_en, gbf_r_bank, gbf_r_addr, gbf_clr_en, gbf_clr_bank, gbf_clr_addr,
            sram_if.sram_valid, sram_if.sram_data, sram_if.sram_addr, bank_free, done, overrun_err};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    psum_gbf_w_num = 1'b0;
    conv_finish = 1'b0;
    ready_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    clr_q.delete();
    exp_base = '0;
    beat_cnt = 0;
    free_cnt = 0;
    stall_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bank(input logic b);
    for (int a = 0; a < DEPTH; a++)
      for (int w = 0; w < DW / 32; w++)
        gbf_mem[b][a][w*32 +: 32] = $urandom();
  endtask

  task automatic push_drain(input logic b);
    beat_t e;
    for (int a = 0; a < DEPTH; a++) begin
      e.data = gbf_mem[b][a];
      e.addr = exp_base + SAW'(a);
      exp_q.push_back(e);
      clr_q.push_back({b, AW'(a)});
    end
    exp_base = exp_base + SAW'(DEPTH);
  endtask

  task automatic toggle();
    @(posedge clk);
    #1 psum_gbf_w_num = ~psum_gbf_w_num;
  endtask

  task automatic wait_drained(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || clr_q.size() != 0) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0 || clr_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d beats/%0d clears outstanding, required 0", tag, exp_q.size(), clr_q.size());
      exp_q.delete();
      clr_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got %0h, required 0", all_outs());
    end
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (all_outs() !== '0 || beat_cnt !== 0) begin
      n_err++;
      $display("FAIL idle_outs: got %0h beats=%0d, required 0 and 0", all_outs(), beat_cnt);
    end
  endtask

  task automatic test_single_drain();
    int idle_cyc = 0;
    int consec = 1;
    do_reset();
    fill_bank(1'b0);
    toggle();
    push_drain(1'b0);
    while (!sram_if.sram_valid && idle_cyc < 20) begin
      @(negedge clk);
      if (!sram_if.sram_valid) idle_cyc++;
    end
    n_vec++;
    if (idle_cyc !== 4) begin
      n_err++;
      $display("FAIL first_valid_latency: got %0d cycles, required 4", idle_cyc);
    end
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      if (sram_if.sram_valid && sram_if.sram_ready) consec++;
    end
    n_vec++;
    if (consec !== DEPTH) begin
      n_err++;
      $display("FAIL throughput: got %0d back-to-back beats, required %0d", consec, DEPTH);
    end
    wait_drained("single");
    n_vec++;
    if (free_cnt !== 1 || beat_cnt !== DEPTH) begin
      n_err++;
      $display("FAIL single_counts: got free=%0d beats=%0d, required 1 and %0d", free_cnt, beat_cnt, DEPTH);
    end
    n_vec++;
    for (int a = 0; a < DEPTH; a++) begin
      if (gbf_mem[0][a] !== '0) begin
        n_err++;
        $display("FAIL bank0_zeroed: got nonzero at entry %0d, required 0", a);
        break;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready_mode = 1'b1;
    fill_bank(1'b0);
    toggle();
    push_drain(1'b0);
    wait_drained("stall");
    n_vec++;
    if (beat_cnt !== DEPTH || free_cnt !== 1 || stall_cnt == 0) begin
      n_err++;
      $display("FAIL stall_counts: got beats=%0d free=%0d stalls=%0d, required %0d, 1, >0",
               beat_cnt, free_cnt, stall_cnt, DEPTH);
    end
    ready_mode = 1'b0;
  endtask

  task automatic test_two_swaps();
    do_reset();
    fill_bank(1'b0);
    fill_bank(1'b1);
    toggle();
    push_drain(1'b0);
    repeat (2) @(posedge clk);
    toggle();
    push_drain(1'b1);
    wait_drained("two_swaps");
    n_vec++;
    if (overrun_err !== 1'b0 || free_cnt !== 2 || beat_cnt !== 2 * DEPTH) begin
      n_err++;
      $display("FAIL two_swaps: got overrun=%0b free=%0d beats=%0d, required 0, 2, %0d",
               overrun_err, free_cnt, beat_cnt, 2 * DEPTH);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    fill_bank(1'b0);
    fill_bank(1'b1);
    toggle();
    push_drain(1'b0);
    repeat (2) @(posedge clk);
    toggle();
    push_drain(1'b1);
    #2;
    n_vec++;
    if (overrun_err !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_early: got %0b, required 0", overrun_err);
    end
    repeat (2) @(posedge clk);
    toggle();
    @(posedge clk);
    #1;
    n_vec++;
    if (overrun_err !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %0b, required 1", overrun_err);
    end
    wait_drained("overrun");
    n_vec++;
    if (overrun_err !== 1'b1 || beat_cnt !== 2 * DEPTH) begin
      n_err++;
      $display("FAIL overrun_sticky: got overrun=%0b beats=%0d, required 1 and %0d", overrun_err, beat_cnt, 2 * DEPTH);
    end
  endtask

  task automatic test_final();
    do_reset();
    fill_bank(1'b0);
    fill_bank(1'b1);
    toggle();
    push_drain(1'b0);
    wait_drained("final_pre");
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_early: got %0b, required 0", done);
    end
    conv_finish = 1'b1;
    push_drain(1'b1);
    @(posedge clk);
    #1 conv_finish = 1'b0;
    wait_drained("final");
    n_vec++;
    if (done !== 1'b1 || free_cnt !== 2) begin
      n_err++;
      $display("FAIL final_done: got done=%0b free=%0d, required 1 and 2", done, free_cnt);
    end
    fill_bank(1'b0);
    toggle();
    repeat (5) @(posedge clk);
    toggle();
    repeat (80) @(posedge clk);
    #1;
    n_vec++;
    if (beat_cnt !== 2 * DEPTH || overrun_err !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_terminal: got beats=%0d overrun=%0b done=%0b, required %0d, 0, 1",
               beat_cnt, overrun_err, done, 2 * DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    do_reset();
    fill_bank(1'b0);
    toggle();
    push_drain(1'b0);
    while (beat_cnt < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (beat_cnt < 10) begin
      n_err++;
      $display("FAIL mid_timeout: got %0d beats, required 10", beat_cnt);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    psum_gbf_w_num = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outs: got %0h, required 0", all_outs());
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (all_outs() !== '0 || clr_q.size() !== DEPTH) begin
      n_err++;
      $display("FAIL mid_reset_hold: got outs=%0h clears_left=%0d, required 0 and %0d", all_outs(), clr_q.size(), DEPTH);
    end
    exp_q.delete();
    clr_q.delete();
    exp_base = '0;
    beat_cnt = 0;
    free_cnt = 0;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    toggle();
    push_drain(1'b0);
    wait_drained("retrigger");
    n_vec++;
    if (beat_cnt !== DEPTH || free_cnt !== 1) begin
      n_err++;
      $display("FAIL retrigger: got beats=%0d free=%0d, required %0d and 1", beat_cnt, free_cnt, DEPTH);
    end
  endtask

  task automatic test_base_wrap();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      fill_bank(psum_gbf_w_num);
      toggle();
      push_drain(~psum_gbf_w_num);
      wait_drained("wrap");
    end
    n_vec++;
    if (beat_cnt !== 3 * DEPTH || free_cnt !== 3 || overrun_err !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_counts: got beats=%0d free=%0d overrun=%0b, required %0d, 3, 0",
               beat_cnt, free_cnt, overrun_err, 3 * DEPTH);
    end
  endtask

  initial begin
    sram_if.sram_ready = 1'b0;
    test_reset();
    test_single_drain();
    test_stall();
    test_two_swaps();
    test_overrun();
    test_final();
    test_reset_mid();
    test_base_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
